// File: rtl/pc_redirect_unit.sv
// PC register and fetch-redirect controller: steers fetch from EX-stage redirects,
// holds under stalls/memory wait, buffers redirects during busy memory, drives flushes.
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             branch_jump_mux_signal,
   input  logic [31:0]      Branch_jump_PC_OUT,
   input  logic             stall,
   input  logic             imem_busy,
   output logic [31:0]      PC,
   output logic [31:0]      PC_PLUS_4,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             redirect_pending,
   output logic             misaligned_target,
   output logic [CNT_W-1:0] redirect_count
);

   typedef enum logic {RUN, PEND} state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        pend_q, pend_d;
   logic               mis_q, mis_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      mis_d   = 1'b0;
      cnt_d   = cnt_q;

      // Every accepted redirect counts and reports misalignment, whatever its destination.
      if (branch_jump_mux_signal) begin
         cnt_d = cnt_q + 1'b1;
         mis_d = |Branch_jump_PC_OUT[1:0];
      end

      unique case (state_q)
         RUN: begin
            if (branch_jump_mux_signal) begin
               if (imem_busy) begin
                  pend_d  = Branch_jump_PC_OUT;
                  state_d = PEND;
               end else begin
                  pc_d = word_align(Branch_jump_PC_OUT);
               end
            end else if (!stall && !imem_busy) begin
               pc_d = pc_q + 32'd4;
            end
         end
         PEND: begin
            if (branch_jump_mux_signal) begin
               pend_d = Branch_jump_PC_OUT;
            end
            // The newest target wins even when it lands on the release cycle.
            if (!imem_busy) begin
               pc_d    = branch_jump_mux_signal ? word_align(Branch_jump_PC_OUT)
                                                : word_align(pend_q);
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   assign PC                = pc_q;
   assign PC_PLUS_4         = pc_q + 32'd4;
   assign redirect_pending  = (state_q == PEND);
   assign if_id_flush       = branch_jump_mux_signal | (state_q == PEND);
   assign id_ex_flush       = branch_jump_mux_signal;
   assign misaligned_target = mis_q;
   assign redirect_count    = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch-redirect rules.
module tb_pc_redirect_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned CNT_W    = 16;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             branch_jump_mux_signal;
   logic [31:0]      Branch_jump_PC_OUT;
   logic             stall;
   logic             imem_busy;
   logic [31:0]      PC;
   logic [31:0]      PC_PLUS_4;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             redirect_pending;
   logic             misaligned_target;
   logic [CNT_W-1:0] redirect_count;

   int checks = 0;
   int errors = 0;

   // Model: a redirect that meets busy memory waits; the latest one wins on release.
   logic [31:0]      m_pc;
   logic             m_wait;
   logic [31:0]      m_tgt;
   logic [CNT_W-1:0] m_cnt;
   logic             m_mis;

   pc_redirect_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .CLK                   (CLK),
      .RESET                 (RESET),
      .branch_jump_mux_signal(branch_jump_mux_signal),
      .Branch_jump_PC_OUT    (Branch_jump_PC_OUT),
      .stall                 (stall),
      .imem_busy             (imem_busy),
      .PC                    (PC),
      .PC_PLUS_4             (PC_PLUS_4),
      .if_id_flush           (if_id_flush),
      .id_ex_flush           (id_ex_flush),
      .redirect_pending      (redirect_pending),
      .misaligned_target     (misaligned_target),
      .redirect_count        (redirect_count)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      if (RESET) begin
         m_pc = RESET_PC; m_wait = 1'b0; m_tgt = '0; m_cnt = '0; m_mis = 1'b0;
      end else begin
         m_mis = branch_jump_mux_signal && (Branch_jump_PC_OUT % 4 != 0);
         if (branch_jump_mux_signal) begin
            m_cnt = m_cnt + 1'b1;
            m_tgt = Branch_jump_PC_OUT;
         end
         if (m_wait || branch_jump_mux_signal) begin
            if (imem_busy) m_wait = 1'b1;
            else begin
               m_pc   = m_tgt - (m_tgt % 4);
               m_wait = 1'b0;
            end
         end else if (!stall && !imem_busy) begin
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      RESET = 1'b0; branch_jump_mux_signal = 1'b0; Branch_jump_PC_OUT = '0;
      stall = 1'b0; imem_busy = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RESET = 1'b1;
      tick(); tick();
      RESET = 1'b0;
      #1;
      checks++;
      if (PC !== 32'h0 || redirect_count !== '0 || redirect_pending !== 1'b0 || misaligned_target !== 1'b0) begin
         errors++;
         $display("FAIL reset_state PC=%h cnt=%0d pend=%b mis=%b required PC=0 cnt=0 pend=0 mis=0",
                  PC, redirect_count, redirect_pending, misaligned_target);
      end
      checks++;
      if (if_id_flush !== 1'b0 || id_ex_flush !== 1'b0) begin
         errors++;
         $display("FAIL reset_flush if_id=%b id_ex=%b required 0 0", if_id_flush, id_ex_flush);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (PC !== 32'(4 * i) || PC_PLUS_4 !== 32'(4 * i + 4)) begin
            errors++;
            $display("FAIL seq_pc[%0d] PC=%h PC_PLUS_4=%h required %h %h", i, PC, PC_PLUS_4, 4 * i, 4 * i + 4);
         end
      end
   endtask

   task automatic test_redirect();
      branch_jump_mux_signal = 1'b1; Branch_jump_PC_OUT = 32'h100;
      #1;
      checks++;
      if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin
         errors++;
         $display("FAIL redirect_flush if_id=%b id_ex=%b required 1 1", if_id_flush, id_ex_flush);
      end
      tick();
      branch_jump_mux_signal = 1'b0;
      #1;
      checks++;
      if (PC !== 32'h100 || redirect_count !== 16'd1 || if_id_flush !== 1'b0) begin
         errors++;
         $display("FAIL redirect_load PC=%h cnt=%0d if_id=%b required 100 1 0", PC, redirect_count, if_id_flush);
      end
      tick();
      checks++;
      if (PC !== 32'h104) begin
         errors++;
         $display("FAIL redirect_next PC=%h required 104", PC);
      end
   endtask

   task automatic test_stall_redirect();
      branch_jump_mux_signal = 1'b1; Branch_jump_PC_OUT = 32'h20;
      tick();
      branch_jump_mux_signal = 1'b0; stall = 1'b1;
      tick();
      checks++;
      if (PC !== 32'h20) begin
         errors++;
         $display("FAIL stall_hold PC=%h required 20", PC);
      end
      branch_jump_mux_signal = 1'b1; Branch_jump_PC_OUT = 32'h80;
      tick();
      checks++;
      if (PC !== 32'h80) begin
         errors++;
         $display("FAIL stall_redirect_wins PC=%h required 80", PC);
      end
      branch_jump_mux_signal = 1'b0;
      tick();
      stall = 1'b0;
      checks++;
      if (PC !== 32'h80 || redirect_count !== 16'd3) begin
         errors++;
         $display("FAIL stall_after PC=%h cnt=%0d required 80 3", PC, redirect_count);
      end
   endtask

   task automatic test_busy_redirect();
      imem_busy = 1'b1; branch_jump_mux_signal = 1'b1; Branch_jump_PC_OUT = 32'h200;
      tick();
      branch_jump_mux_signal = 1'b0;
      #1;
      checks++;
      if (redirect_pending !== 1'b1 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b0 || PC !== 32'h80) begin
         errors++;
         $display("FAIL busy_pend pend=%b if_id=%b id_ex=%b PC=%h required 1 1 0 80",
                  redirect_pending, if_id_flush, id_ex_flush, PC);
      end
      tick();
      branch_jump_mux_signal = 1'b1; Branch_jump_PC_OUT = 32'h300;
      tick();
      branch_jump_mux_signal = 1'b0;
      tick();
      imem_busy = 1'b0;
      #1;
      checks++;
      if (redirect_pending !== 1'b1 || if_id_flush !== 1'b1 || PC !== 32'h80) begin
         errors++;
         $display("FAIL busy_release_cycle pend=%b if_id=%b PC=%h required 1 1 80", redirect_pending, if_id_flush, PC);
      end
      tick();
      checks++;
      if (PC !== 32'h300 || redirect_pending !== 1'b0 || redirect_count !== 16'd5) begin
         errors++;
         $display("FAIL busy_target PC=%h pend=%b cnt=%0d required 300 0 5", PC, redirect_pending, redirect_count);
      end
   endtask

   task automatic test_misaligned();
      branch_jump_mux_signal = 1'b1; Branch_jump_PC_OUT = 32'h1002;
      tick();
      branch_jump_mux_signal = 1'b0;
      checks++;
      if (PC !== 32'h1000 || misaligned_target !== 1'b1) begin
         errors++;
         $display("FAIL misaligned_load PC=%h mis=%b required 1000 1", PC, misaligned_target);
      end
      tick();
      checks++;
      if (PC !== 32'h1004 || misaligned_target !== 1'b0) begin
         errors++;
         $display("FAIL misaligned_clear PC=%h mis=%b required 1004 0", PC, misaligned_target);
      end
   endtask

   task automatic test_wrap();
      branch_jump_mux_signal = 1'b1; Branch_jump_PC_OUT = 32'hFFFF_FFFC;
      tick();
      branch_jump_mux_signal = 1'b0;
      checks++;
      if (PC !== 32'hFFFF_FFFC || PC_PLUS_4 !== 32'h0) begin
         errors++;
         $display("FAIL wrap_top PC=%h PC_PLUS_4=%h required fffffffc 0", PC, PC_PLUS_4);
      end
      tick();
      checks++;
      if (PC !== 32'h0) begin
         errors++;
         $display("FAIL wrap_zero PC=%h required 0", PC);
      end
   endtask

   task automatic test_reset_in_pend();
      imem_busy = 1'b1; branch_jump_mux_signal = 1'b1; Branch_jump_PC_OUT = 32'h400;
      tick();
      branch_jump_mux_signal = 1'b0;
      checks++;
      if (redirect_pending !== 1'b1) begin
         errors++;
         $display("FAIL pend_entry pend=%b required 1", redirect_pending);
      end
      RESET = 1'b1;
      tick();
      RESET = 1'b0; imem_busy = 1'b0;
      #1;
      checks++;
      if (redirect_pending !== 1'b0 || PC !== RESET_PC || redirect_count !== '0 || if_id_flush !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_pend pend=%b PC=%h cnt=%0d if_id=%b required 0 %h 0 0",
                  redirect_pending, PC, redirect_count, if_id_flush, RESET_PC);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         RESET                  = ($urandom_range(0, 59) == 0);
         branch_jump_mux_signal = ($urandom_range(0, 3) == 0);
         Branch_jump_PC_OUT     = $urandom;
         stall                  = ($urandom_range(0, 3) == 0);
         imem_busy              = ($urandom_range(0, 2) == 0);
         #1;
         if (!RESET) begin
            checks++;
            if (if_id_flush !== (branch_jump_mux_signal | m_wait) || id_ex_flush !== branch_jump_mux_signal) begin
               errors++;
               $display("FAIL rand_flush[%0d] if_id=%b id_ex=%b required %b %b", n, if_id_flush, id_ex_flush,
                        branch_jump_mux_signal | m_wait, branch_jump_mux_signal);
            end
         end
         tick();
         checks++;
         if (PC !== m_pc || PC_PLUS_4 !== m_pc + 32'd4 || redirect_pending !== m_wait ||
             misaligned_target !== m_mis || redirect_count !== m_cnt) begin
            errors++;
            $display("FAIL rand_state[%0d] PC=%h pend=%b mis=%b cnt=%0d required PC=%h pend=%b mis=%b cnt=%0d",
                     n, PC, redirect_pending, misaligned_target, redirect_count, m_pc, m_wait, m_mis, m_cnt);
         end
      end
      idle_inputs();
   endtask

   initial begin
      m_pc = RESET_PC; m_wait = 1'b0; m_tgt = '0; m_cnt = '0; m_mis = 1'b0;
      idle_inputs();
      #1;
      test_reset();
      test_redirect();
      test_stall_redirect();
      test_busy_redirect();
      test_misaligned();
      test_wrap();
      test_reset_in_pend();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter register and fetch-redirect controller sitting at the front of the five-stage pipeline. Consumes the taken/target pair produced by the EX-stage branch/jump unit and steers instruction fetch. Holds the PC under hazard stalls and instruction-memory wait states, and buffers a redirect that arrives while memory is busy. Generates flush pulses for the wrong-path instructions in IF/ID and ID/EX, and counts taken redirects for performance monitoring.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- branch_jump_mux_signal  in  1  redirect request from EX (taken branch or jump).
- Branch_jump_PC_OUT  in  32  redirect target address.
- stall  in  1  hazard-unit stall; hold PC.
- imem_busy  in  1  instruction memory not ready; fetch at PC must be held.
- PC  out  32  current fetch address (registered).
- PC_PLUS_4  out  32  PC + 4, combinational from PC.
- if_id_flush  out  1  kill IF/ID contents at next edge.
- id_ex_flush  out  1  kill ID/EX contents at next edge.
- redirect_pending  out  1  high while a redirect target is buffered (state PEND).
- misaligned_target  out  1  registered one-cycle pulse: accepted target had bits [1:0] ≠ 0.
- redirect_count  out  CNT_W  number of redirects accepted since reset; wraps.

## Operation
- States: RUN, PEND. Reset state RUN.
- Reset (RESET=1 at edge): PC=RESET_PC, state=RUN, pending target=0, misaligned_target=0, redirect_count=0. RESET overrides all inputs.
- Combinational outputs during reset cycle: flushes follow the rules below. Bench checks them only after reset deasserts.
- RUN, priority order at each edge:
  1. branch_jump_mux_signal=1, imem_busy=0: PC ← {target[31:2],2'b00}; count +1; stay RUN.
  2. branch_jump_mux_signal=1, imem_busy=1: pending ← target; count +1; go PEND; PC unchanged.
  3. stall=1 or imem_busy=1: PC unchanged.
  4. Otherwise: PC ← PC+4, wrapping modulo 2^32. 32'hFFFF_FFFC → 0.
- PEND, at each edge:
  - New branch_jump_mux_signal=1 overwrites pending target and counts +1.
  - imem_busy=0: PC ← {pending[31:2],2'b00}, or {new target[31:2],2'b00} if a redirect arrives the same cycle; go RUN.
  - imem_busy=1: stay PEND.
  - stall is ignored in PEND.
- Redirect beats stall when both are asserted.
- Flushes are combinational:
  - if_id_flush = branch_jump_mux_signal | (state==PEND).
  - id_ex_flush = branch_jump_mux_signal.
- misaligned_target is set for one cycle after any edge that accepts a target, into PC or into pending, with target[1:0] ≠ 0. Otherwise 0.
- redirect_count wraps from 2^CNT_W−1 to 0.

## Timing
- Redirect latency: request in cycle n with memory ready → PC=target in cycle n+1.
- Wrong-path instructions are killed at the same edge as the PC load.
- Busy redirect: request in cycle n → redirect_pending=1 from n+1. PC=target one cycle after the first cycle with imem_busy=0.
- Stall has zero-cycle effect: PC holds at the edge that sees stall=1.
- PC_PLUS_4 is valid in the same cycle as PC.
- No reset-to-output combinational path beyond the registered PC.

## Test plan
- Reset then 4 idle cycles, RESET_PC=0 → PC sequence 0, 4, 8, 12, 16; flushes 0; redirect_count=0.
- At PC=0x10, assert branch_jump_mux_signal with target 0x100 for one cycle → if_id_flush=id_ex_flush=1 that cycle; next PC=0x100, then 0x104; redirect_count=1.
- stall=1 for 3 cycles at PC=0x20, with a redirect to 0x80 in the 2nd stall cycle → PC holds 0x20, then 0x80; redirect wins.
- imem_busy=1 for 4 cycles; redirect to 0x200 in busy cycle 1, then to 0x300 in busy cycle 3:
  - redirect_pending=1 and if_id_flush=1 through PEND.
  - After busy drops, PC=0x300; redirect_count +2.
- Target 0x1002 → PC=0x1000; misaligned_target pulses exactly one cycle.
- PC=0xFFFF_FFFC with no events → PC=0x0.
- RESET asserted while in PEND → state RUN, PC=RESET_PC, redirect_pending=0, count=0.
